// File: rtl/endstop_event_ctrl.sv
// Round-robin event latch for a bank of debounce channels, with a sticky motion-stop flag.
// Optional capture timestamp counter is built only when ENDSTOP_TIMESTAMP_EN is defined.
module endstop_event_ctrl #(
    parameter int NCH = 4,
    parameter int CW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   ch_value,
    input  logic [NCH-1:0]   ch_changed,
    input  logic [8*NCH-1:0] ch_cycles,
    output logic [NCH-1:0]   ch_unlock,
    input  logic [NCH-1:0]   ev_enable,
    input  logic [NCH-1:0]   stop_mask,
    input  logic             stop_clear,
    output logic             ev_valid,
    output logic [CW-1:0]    ev_channel,
    output logic             ev_value,
    output logic [7:0]       ev_cycles,
    output logic [31:0]      ev_timestamp,
    input  logic             ev_ack,
    output logic             irq,
    output logic             stop_out
);
    typedef enum logic [1:0] {IDLE, HOLD, UNLOCK, SETTLE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   ptr_reg, ptr_next;
    logic            ev_valid_reg, ev_valid_next;
    logic [CW-1:0]   ev_channel_reg, ev_channel_next;
    logic            ev_value_reg, ev_value_next;
    logic [7:0]      ev_cycles_reg, ev_cycles_next;
    logic            stop_reg, stop_next;

    logic [NCH-1:0]  pending;
    logic [NCH-1:0]  at_or_above;
    logic [NCH-1:0]  pending_upper;
    logic [CW-1:0]   grant_idx;
    logic            grant_take;
    logic [7:0]      cycles_arr [NCH];

    assign pending       = ch_changed & ev_enable;
    assign pending_upper = pending & at_or_above;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign at_or_above[gi] = (CW'(gi) >= ptr_reg);
            assign cycles_arr[gi]  = ch_cycles[8*gi +: 8];
            assign ch_unlock[gi]   = (state_reg == UNLOCK) && (ev_channel_reg == CW'(gi));
        end
    endgenerate

    function automatic logic [CW-1:0] lowest_set(input logic [NCH-1:0] v);
        lowest_set = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = CW'(i);
        end
    endfunction

    // Wrap-around search: prefer pending channels at or above the pointer, else restart from 0.
    assign grant_idx  = (|pending_upper) ? lowest_set(pending_upper) : lowest_set(pending);
    assign grant_take = (state_reg == IDLE) && (|pending);

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        ev_valid_next   = ev_valid_reg;
        ev_channel_next = ev_channel_reg;
        ev_value_next   = ev_value_reg;
        ev_cycles_next  = ev_cycles_reg;
        case (state_reg)
            IDLE: begin
                if (grant_take) begin
                    ev_channel_next = grant_idx;
                    ev_value_next   = ch_value[grant_idx];
                    ev_cycles_next  = cycles_arr[grant_idx];
                    ev_valid_next   = 1'b1;
                    state_next      = HOLD;
                end
            end
            HOLD: begin
                if (ev_ack) begin
                    ev_valid_next = 1'b0;
                    state_next    = UNLOCK;
                end
            end
            UNLOCK: begin
                ptr_next   = (ev_channel_reg == CW'(NCH - 1)) ? '0 : ev_channel_reg + CW'(1);
                state_next = SETTLE;
            end
            SETTLE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Set term is ORed last so a fresh qualifying change beats a simultaneous clear.
    assign stop_next = (stop_reg & ~stop_clear) | (|(ch_changed & ch_value & stop_mask));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            ev_valid_reg   <= 1'b0;
            ev_channel_reg <= '0;
            ev_value_reg   <= 1'b0;
            ev_cycles_reg  <= '0;
            stop_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            ev_valid_reg   <= ev_valid_next;
            ev_channel_reg <= ev_channel_next;
            ev_value_reg   <= ev_value_next;
            ev_cycles_reg  <= ev_cycles_next;
            stop_reg       <= stop_next;
        end
    end

`ifdef ENDSTOP_TIMESTAMP_EN
    logic [31:0] ts_count_reg;
    logic [31:0] ev_timestamp_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ts_count_reg     <= '0;
            ev_timestamp_reg <= '0;
        end else begin
            ts_count_reg <= ts_count_reg + 32'd1;
            if (grant_take) ev_timestamp_reg <= ts_count_reg;
        end
    end

    assign ev_timestamp = ev_timestamp_reg;
`else
    assign ev_timestamp = '0;
`endif

    assign ev_valid   = ev_valid_reg;
    assign ev_channel = ev_channel_reg;
    assign ev_value   = ev_value_reg;
    assign ev_cycles  = ev_cycles_reg;
    assign stop_out   = stop_reg;
    assign irq        = ev_valid_reg | stop_reg;
endmodule

// File: doc/endstop_event_ctrl.md
Name: endstop_event_ctrl

Overview:
- Services a bank of NCH debounce channels (endstops, probe, door switches).
- Round-robin arbitrates pending channel changes and latches one event at a time into a host-readable event register.
- Holds the event until the host acknowledges it, then pulses the channel's unlock.
- Independently raises a sticky motion-stop flag when a stop-enabled channel goes active.

Parameters:
NCH, 4, number of debounce channels served (2..16)
CW, 2, channel index width, must equal clog2(NCH)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ch_value  in  NCH  per-channel debounced level (debounce sig_out)
ch_changed  in  NCH  per-channel locked-change flag (debounce sig_changed)
ch_cycles  in  8*NCH  per-channel change counters, channel i at [8i+7:8i]
ch_unlock  out  NCH  one-cycle unlock pulse to channel i
ev_enable  in  NCH  channels allowed to generate events; masked channels are never granted
stop_mask  in  NCH  channels whose rising level sets stop_out
stop_clear  in  1  clears stop_out
ev_valid  out  1  event register holds an unacknowledged event
ev_channel  out  CW  channel index of held event
ev_value  out  1  level captured with event
ev_cycles  out  8  ch_cycles of granted channel at capture
ev_timestamp  out  32  capture time (see Optional Feature)
ev_ack  in  1  host acknowledge, sampled only while ev_valid=1
irq  out  1  equals ev_valid | stop_out
stop_out  out  1  sticky motion-stop request

Behaviour:
- Reset values: all outputs 0. FSM=IDLE. Round-robin pointer=0. Timestamp counter=0.
- The clock is clk. Reset is synchronous and active-high.
- pending = ch_changed & ev_enable.

FSM:
- IDLE: if pending != 0, grant the first set bit searching from the pointer upward with wrap-around.
  - Latch ev_channel, ev_value=ch_value[g], ev_cycles=ch_cycles[g], ev_timestamp.
  - Set ev_valid=1 on the next edge. Go to HOLD.
  - Grant-to-ev_valid latency: 1 cycle.
- HOLD: ev_valid=1. Event fields stay frozen regardless of channel activity.
  - On ev_ack=1: ev_valid<=0, go to UNLOCK.
- UNLOCK: ch_unlock[ev_channel]=1 for exactly this one cycle. Pointer <= ev_channel+1, wrapping at NCH. Go to SETTLE.
- SETTLE: one idle cycle so the unlocked channel's ch_changed can drop. No grant is made here. Go to IDLE.
- Minimum event-to-event spacing after ack: 3 cycles.

Arbitration and edge cases:
- ev_ack while not in HOLD is ignored.
- A channel that is unlocked and immediately changes again is granted again only after every other pending channel ahead of it in round-robin order.
- Channel changes that occur while the channel is locked are not lost. They are reflected in ch_cycles at the channel's next grant.
- ev_enable deasserted for the granted channel during HOLD has no effect on the held event.

stop_out:
- Next value = (stop_out & ~stop_clear) | |(ch_changed & ch_value & stop_mask).
- Set wins over simultaneous clear.
- stop_out is independent of the FSM. It asserts 1 cycle after a qualifying change even while another event is held.

Reset mid-operation:
- Returns the FSM to IDLE and drops ev_valid.
- No unlock pulse is issued; the channels are reset by the same reset.

Optional Feature:
- Macro: ENDSTOP_TIMESTAMP_EN.
- Defined: a 32-bit free-running counter increments every clk, wrapping at 2^32. Its value in the grant cycle is latched into ev_timestamp.
- Undefined: no counter is built and ev_timestamp is constant 0. All other behaviour is identical.

Test Plan:
1. Single event: ch_changed=0b0100, ch_value[2]=1, ch_cycles[23:16]=5 → next cycle ev_valid=1, ev_channel=2, ev_value=1, ev_cycles=5. Pulse ev_ack → ch_unlock=0b0100 for exactly 1 cycle, the cycle after ev_valid falls.
2. Round-robin: pointer=0, ch_changed=0b1011 held (each channel re-asserts after unlock) → grant order 0,1,3,0,1,3.
3. Masking: ev_enable=0b1110, ch_changed=0b0001 → ev_valid stays 0 for 20 cycles and ch_unlock stays 0. Set ev_enable[0] → event for channel 0 next cycle.
4. Stop: stop_mask=0b0010, ch_changed[1]=1 with ch_value[1]=1 during HOLD of channel 0 → stop_out=1 next cycle, irq=1. Assert stop_clear together with a new qualifying change → stop_out stays 1. stop_clear alone → 0.
5. Reset mid-HOLD: reset for 1 cycle → ev_valid=0, stop_out=0, no ch_unlock pulse, pointer=0. With ENDSTOP_TIMESTAMP_EN, a grant 10 cycles after reset release gives ev_timestamp=10; without the macro it gives ev_timestamp=0.
